core_exec_ctrl: RTL and testbench
=================================

Name: core_exec_ctrl

Overview:
- Run-control sequencer for the 4-bit accumulator core.
- Owns a single clock-enable that advances PC and registers RA/RB/RO one instruction per enabled cycle.
- Accepts run/halt/single-step/program-load commands over a valid/ready port and writes the 16x8 instruction memory during load.
- Keeps a retired-instruction counter; an optional PC breakpoint is included.

Parameters:
CNT_W, 16, width of retired-instruction counter instr_cnt (saturating)
PC_W, 4, program counter / imem address width
INST_W, 8, instruction word width

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  synchronous active-low reset, sampled on rising edge of clk
cmd_valid  input  1  command present
cmd_ready  output  1  controller accepts command this cycle
cmd_op  input  2  0=RUN, 1=HALT, 2=STEP, 3=LOAD
cmd_addr  input  PC_W  imem write address (LOAD only)
cmd_data  input  INST_W  imem write data (LOAD only)
pc  input  PC_W  current core PC
core_en  output  1  core advances one instruction this cycle
imem_we  output  1  instruction memory write strobe
imem_waddr  output  PC_W  imem write address
imem_wdata  output  INST_W  imem write data
halted  output  1  controller in IDLE
instr_cnt  output  CNT_W  retired instructions, saturating
bp_hit  output  1  one-cycle pulse on breakpoint stop (BREAKPOINT_EN only, else tied 0)

Behaviour:
- Reset: resetn is synchronous and active-low, sampled on rising edge of clk; there is a single clock.
  - When resetn=0 at an edge: state=IDLE, instr_cnt=0, imem_we=0, imem_waddr=0, imem_wdata=0, bp_hit=0.
  - Reset overrides any in-flight command, including a LOAD in progress, whose write is dropped.
- Handshake: command transfers on a cycle with cmd_valid & cmd_ready. cmd_ready is a combinational decode of registered state: 1 in IDLE and RUN, 0 in STEP and LOAD.
- core_en is combinational from registered state: 1 in STEP, and 1 in RUN unless a breakpoint match suppresses it.
- States:
  - IDLE (halted=1, core_en=0):
    - RUN -> RUN
    - STEP -> STEP
    - LOAD -> LOAD; cmd_addr/cmd_data are registered into imem_waddr/imem_wdata
    - HALT accepted, no effect
  - RUN (core_en=1):
    - HALT accepted at cycle t: core_en still 1 at t (that instruction retires), IDLE at t+1
    - RUN/STEP/LOAD accepted and discarded, state unchanged
  - STEP: exactly one cycle, core_en=1, then IDLE.
  - LOAD: exactly one cycle, imem_we=1 with registered addr/data, then IDLE. imem_we is 0 in all other states.
- Latency:
  - RUN/STEP accepted at t -> first core_en at t+1.
  - LOAD accepted at t -> imem write at t+1; next command can be accepted at t+2.
- instr_cnt: +1 on every cycle with core_en=1; holds at 2^CNT_W-1 (no wrap). Cleared only by reset.
- No PC wrap handling here: the core's PC wraps 15->0 naturally and the controller keeps running.

Optional Feature:
- Macro: CORE_EXEC_CTRL_BREAKPOINT_EN.
- Defined:
  - Extra inputs bp_en (1 bit) and bp_addr (PC_W bits).
  - In RUN, if bp_en & (pc==bp_addr) and the cycle is not the first RUN cycle after entering RUN:
    - core_en=0 that cycle (instruction at bp_addr does not execute)
    - next state IDLE
    - bp_hit=1 for one cycle, registered, asserted the cycle state becomes IDLE
  - The first-cycle exemption lets RUN resume from a breakpoint.
  - STEP ignores breakpoints.
  - A HALT and a breakpoint in the same cycle: the breakpoint wins (core_en=0) and bp_hit pulses.
- Undefined: the ports are absent, bp_hit is tied 0, and there is no breakpoint logic.

Test Plan:
- Reset then idle 5 cycles -> halted=1, core_en=0, instr_cnt=0, cmd_ready=1, imem_we=0.
- LOAD addr=3 data=0x5A at t -> imem_we=1, waddr=3, wdata=0x5A at t+1; cmd_ready=0 at t+1; second LOAD accepted at t+2.
- STEP three times back-to-back (valid held) -> exactly 3 core_en pulses on alternate cycles; instr_cnt=3; halted between steps.
- RUN at t, HALT at t+10 -> core_en=1 for cycles t+1..t+10, instr_cnt=10, halted at t+11; STEP/LOAD sent mid-run are discarded (no imem_we).
- CNT_W=4, RUN 20 cycles -> instr_cnt saturates at 15; assert resetn=0 mid-RUN with LOAD pending -> IDLE next cycle, instr_cnt=0, no imem_we.
- (BREAKPOINT_EN) bp_addr=6, RUN from pc=0 incrementing -> core_en=0 when pc=6, bp_hit single pulse, halted=1; RUN again -> executes pc=6 on first cycle, continues.

Source files
------------

// File: rtl/core_exec_ctrl_if.sv
// Command port of the run-control sequencer: valid/ready handshake carrying
// RUN/HALT/STEP/LOAD opcodes plus the imem write address and data for LOAD.
interface core_exec_ctrl_if #(
    parameter int PC_W   = 4,
    parameter int INST_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [PC_W-1:0]   cmd_addr;
    logic [INST_W-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/core_exec_ctrl.sv
// Run-control sequencer for the 4-bit accumulator core: owns core_en, writes imem
// on LOAD and counts retired instructions. Optional PC breakpoint: CORE_EXEC_CTRL_BREAKPOINT_EN.
module core_exec_ctrl #(
    parameter int CNT_W  = 16,
    parameter int PC_W   = 4,
    parameter int INST_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    core_exec_ctrl_if.slave   cmd,
    input  logic [PC_W-1:0]   pc,
`ifdef CORE_EXEC_CTRL_BREAKPOINT_EN
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
`endif
    output logic              core_en,
    output logic              imem_we,
    output logic [PC_W-1:0]   imem_waddr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic              bp_hit
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_LOAD
    } state_e;

    typedef enum logic [1:0] {
        OP_RUN  = 2'd0,
        OP_HALT = 2'd1,
        OP_STEP = 2'd2,
        OP_LOAD = 2'd3
    } op_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   waddr_q, waddr_d;
    logic [INST_W-1:0] wdata_q, wdata_d;
    op_e               op;
    logic              cmd_fire;
    logic              bp_stop;

    assign op            = op_e'(cmd.cmd_op);
    assign cmd.cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN);
    assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;
    assign halted        = (state_q == S_IDLE);
    assign imem_waddr    = waddr_q;
    assign imem_wdata    = wdata_q;
    assign instr_cnt     = cnt_q;

`ifdef CORE_EXEC_CTRL_BREAKPOINT_EN
    logic first_q, first_d;
    logic bp_hit_q, bp_hit_d;

    // The first RUN cycle is exempt so a RUN issued while parked on the
    // breakpoint address executes that instruction instead of stopping again.
    assign first_d  = (state_q != S_RUN);
    assign bp_stop  = (state_q == S_RUN) && !first_q && bp_en && (pc == bp_addr);
    assign bp_hit_d = bp_stop;
    assign bp_hit   = bp_hit_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            first_q  <= 1'b1;
            bp_hit_q <= 1'b0;
        end else begin
            first_q  <= first_d;
            bp_hit_q <= bp_hit_d;
        end
    end
`else
    // pc only feeds the breakpoint comparator; fold it into a sink here.
    logic unused_pc;
    assign unused_pc = ^pc;
    assign bp_stop   = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned; that is what keeps latches from being inferred.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        core_en = 1'b0;
        imem_we = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (op)
                        OP_RUN:  state_d = S_RUN;
                        OP_STEP: state_d = S_STEP;
                        OP_LOAD: begin
                            state_d = S_LOAD;
                            waddr_d = cmd.cmd_addr;
                            wdata_d = cmd.cmd_data;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // A breakpoint outranks a HALT arriving in the same cycle.
                if (bp_stop) begin
                    state_d = S_IDLE;
                end else begin
                    core_en = 1'b1;
                    if (cmd_fire && op == OP_HALT) state_d = S_IDLE;
                end
            end
            S_STEP: begin
                core_en = 1'b1;
                state_d = S_IDLE;
            end
            S_LOAD: begin
                imem_we = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d = (core_en && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_core_exec_ctrl.sv
// Self-checking bench for core_exec_ctrl: directed scenarios plus random command
// traffic, checked each cycle against a behavioural model of the run-control rules.
module tb_core_exec_ctrl;

    localparam int PC_W   = 4;
    localparam int INST_W = 8;
    localparam int CNT_W  = 16;
    localparam int CNT_S  = 4;
`ifdef CORE_EXEC_CTRL_BREAKPOINT_EN
    localparam bit HAS_BP = 1'b1;
`else
    localparam bit HAS_BP = 1'b0;
`endif

    localparam logic [1:0] C_RUN  = 2'd0;
    localparam logic [1:0] C_HALT = 2'd1;
    localparam logic [1:0] C_STEP = 2'd2;
    localparam logic [1:0] C_LOAD = 2'd3;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [PC_W-1:0]   pc = '0;
    logic              bp_en = 1'b0;
    logic [PC_W-1:0]   bp_addr = '0;

    logic              core_en, imem_we, halted, bp_hit;
    logic [PC_W-1:0]   imem_waddr;
    logic [INST_W-1:0] imem_wdata;
    logic [CNT_W-1:0]  instr_cnt;

    logic              core_en_s, imem_we_s, halted_s, bp_hit_s;
    logic [PC_W-1:0]   imem_waddr_s;
    logic [INST_W-1:0] imem_wdata_s;
    logic [CNT_S-1:0]  instr_cnt_s;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: which mode the controller is in, plus the count of
    // instructions retired since reset (saturation applied at comparison time).
    bit                m_run, m_step, m_load, m_first, m_bp_hit;
    logic [PC_W-1:0]   m_addr;
    logic [INST_W-1:0] m_data;
    longint            m_retired;
    bit                obs_en;

    core_exec_ctrl_if #(.PC_W(PC_W), .INST_W(INST_W)) cmd_if ();
    core_exec_ctrl_if #(.PC_W(PC_W), .INST_W(INST_W)) cmd_if_s ();

    assign cmd_if_s.cmd_valid = cmd_if.cmd_valid;
    assign cmd_if_s.cmd_op    = cmd_if.cmd_op;
    assign cmd_if_s.cmd_addr  = cmd_if.cmd_addr;
    assign cmd_if_s.cmd_data  = cmd_if.cmd_data;

    core_exec_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd        (cmd_if),
        .pc         (pc),
`ifdef CORE_EXEC_CTRL_BREAKPOINT_EN
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
`endif
        .core_en    (core_en),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .halted     (halted),
        .instr_cnt  (instr_cnt),
        .bp_hit     (bp_hit)
    );

    core_exec_ctrl #(.CNT_W(CNT_S), .PC_W(PC_W), .INST_W(INST_W)) dut_s (
        .clk        (clk),
        .resetn     (resetn),
        .cmd        (cmd_if_s),
        .pc         (pc),
`ifdef CORE_EXEC_CTRL_BREAKPOINT_EN
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
`endif
        .core_en    (core_en_s),
        .imem_we    (imem_we_s),
        .imem_waddr (imem_waddr_s),
        .imem_wdata (imem_wdata_s),
        .halted     (halted_s),
        .instr_cnt  (instr_cnt_s),
        .bp_hit     (bp_hit_s)
    );

    always #5 clk = ~clk;

    // Stand-in for the core: PC advances once per enabled cycle and wraps.
    always @(posedge clk) begin
        if (!resetn) pc <= '0;
        else if (core_en) pc <= pc + PC_W'(1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_run = 0; m_step = 0; m_load = 0; m_first = 0; m_bp_hit = 0;
        m_addr = '0; m_data = '0; m_retired = 0;
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model by the rules for the edge about to occur.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [PC_W-1:0] a,
                         input logic [INST_W-1:0] d, input logic rn);
        bit idle, e_ready, e_en, stop, fire, hit;
        logic [CNT_W-1:0] e_cnt;
        logic [CNT_S-1:0] e_cnt_s;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_addr  = a;
        cmd_if.cmd_data  = d;
        resetn           = rn;
        #1;
        idle    = !(m_run || m_step || m_load);
        stop    = HAS_BP && m_run && !m_first && bp_en && (pc == bp_addr);
        e_ready = idle || m_run;
        e_en    = m_step || (m_run && !stop);
        e_cnt   = (m_retired >= longint'(2**CNT_W - 1)) ? '1 : CNT_W'(m_retired);
        e_cnt_s = (m_retired >= longint'(2**CNT_S - 1)) ? '1 : CNT_S'(m_retired);
        obs_en  = core_en;
        vectors++;
        if ({core_en, cmd_if.cmd_ready, halted, imem_we, bp_hit, imem_waddr, imem_wdata}
            !== {e_en, e_ready, idle, m_load, m_bp_hit, m_addr, m_data}) begin
            miscompares++;
            $display("FAIL outputs @%0t: got en=%b rdy=%b halt=%b we=%b bp=%b wa=%h wd=%h, want en=%b rdy=%b halt=%b we=%b bp=%b wa=%h wd=%h",
                     $time, core_en, cmd_if.cmd_ready, halted, imem_we, bp_hit, imem_waddr, imem_wdata,
                     e_en, e_ready, idle, m_load, m_bp_hit, m_addr, m_data);
        end
        if (instr_cnt !== e_cnt) begin
            miscompares++;
            $display("FAIL instr_cnt @%0t: got %0d want %0d", $time, instr_cnt, e_cnt);
        end
        if ({core_en_s, cmd_if_s.cmd_ready, halted_s, imem_we_s, bp_hit_s, imem_waddr_s, imem_wdata_s, instr_cnt_s}
            !== {e_en, e_ready, idle, m_load, m_bp_hit, m_addr, m_data, e_cnt_s}) begin
            miscompares++;
            $display("FAIL narrow_cnt_inst @%0t: got en=%b cnt=%0d, want en=%b cnt=%0d",
                     $time, core_en_s, instr_cnt_s, e_en, e_cnt_s);
        end
        if (!rn) begin
            model_clear();
        end else begin
            if (e_en) m_retired++;
            fire = v && e_ready;
            hit  = 0;
            if (idle) begin
                if (fire) begin
                    case (op)
                        C_RUN:  begin m_run = 1; m_first = 1; end
                        C_STEP: m_step = 1;
                        C_LOAD: begin m_load = 1; m_addr = a; m_data = d; end
                        default: ;
                    endcase
                end
            end else if (m_run) begin
                if (stop) begin m_run = 0; hit = 1; end
                else if (fire && op == C_HALT) m_run = 0;
                m_first = 0;
            end else begin
                m_step = 0;
                m_load = 0;
            end
            m_bp_hit = hit;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, C_HALT, '0, '0, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b0, C_HALT, '0, '0, 1'b0);
        cycle(1'b0, C_HALT, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        // First edge under reset brings the DUT out of X; nothing to compare yet.
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = C_HALT;
        cmd_if.cmd_addr  = '0;
        cmd_if.cmd_data  = '0;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_clear();
        do_reset();
        for (int i = 0; i < 5; i++) idle_cycle();
        vectors++;
        if ({halted, core_en, cmd_if.cmd_ready, imem_we, bp_hit} !== 5'b10100 || instr_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: got halt=%b en=%b rdy=%b we=%b bp=%b cnt=%0d, want 1 0 1 0 0 cnt=0",
                     halted, core_en, cmd_if.cmd_ready, imem_we, bp_hit, instr_cnt);
        end
    endtask

    task automatic test_load();
        do_reset();
        cycle(1'b1, C_LOAD, 4'd3, 8'h5A, 1'b1);
        vectors++;
        if ({imem_we, cmd_if.cmd_ready} !== 2'b10 || imem_waddr !== 4'd3 || imem_wdata !== 8'h5A) begin
            miscompares++;
            $display("FAIL load_write: got we=%b rdy=%b wa=%h wd=%h, want we=1 rdy=0 wa=3 wd=5a",
                     imem_we, cmd_if.cmd_ready, imem_waddr, imem_wdata);
        end
        cycle(1'b1, C_LOAD, 4'd9, 8'hC3, 1'b1);
        vectors++;
        if (cmd_if.cmd_ready !== 1'b1 || imem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL load_ready_t2: got rdy=%b we=%b, want rdy=1 we=0", cmd_if.cmd_ready, imem_we);
        end
        cycle(1'b1, C_LOAD, 4'd9, 8'hC3, 1'b1);
        vectors++;
        if (imem_we !== 1'b1 || imem_waddr !== 4'd9 || imem_wdata !== 8'hC3) begin
            miscompares++;
            $display("FAIL load_second: got we=%b wa=%h wd=%h, want we=1 wa=9 wd=c3",
                     imem_we, imem_waddr, imem_wdata);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back_step();
        logic [6:0] seen;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(i < 5, C_STEP, '0, '0, 1'b1);
            seen[i] = obs_en;
        end
        vectors++;
        if (seen !== 7'b0101010 || instr_cnt !== 16'd3 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL step_b2b: got pattern=%b cnt=%0d halt=%b, want pattern=0101010 cnt=3 halt=1",
                     seen, instr_cnt, halted);
        end
    endtask

    task automatic test_run_halt();
        int ens, wes;
        do_reset();
        ens = 0; wes = 0;
        for (int k = 0; k <= 10; k++) begin
            if (k == 0)       cycle(1'b1, C_RUN,  '0, '0, 1'b1);
            else if (k == 4)  cycle(1'b1, C_STEP, '0, '0, 1'b1);
            else if (k == 6)  cycle(1'b1, C_LOAD, 4'd2, 8'hEE, 1'b1);
            else if (k == 10) cycle(1'b1, C_HALT, '0, '0, 1'b1);
            else              idle_cycle();
            ens += int'(obs_en);
            wes += int'(imem_we);
        end
        vectors++;
        if (ens != 10 || wes != 0 || instr_cnt !== 16'd10 || halted !== 1'b1 || imem_waddr !== 4'd0) begin
            miscompares++;
            $display("FAIL run_halt: got en_cycles=%0d we_cycles=%0d cnt=%0d halt=%b wa=%h, want 10 0 10 1 0",
                     ens, wes, instr_cnt, halted, imem_waddr);
        end
        idle_cycle();
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        cycle(1'b1, C_RUN, '0, '0, 1'b1);
        for (int i = 0; i < 20; i++) idle_cycle();
        vectors++;
        if (instr_cnt_s !== 4'd15 || instr_cnt !== 16'd20 || core_en !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate: got narrow=%0d wide=%0d en=%b, want 15 20 1", instr_cnt_s, instr_cnt, core_en);
        end
        cycle(1'b1, C_LOAD, 4'd5, 8'hAA, 1'b0);
        vectors++;
        if ({halted, imem_we, core_en} !== 3'b100 || instr_cnt !== '0 || instr_cnt_s !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_run: got halt=%b we=%b en=%b cnt=%0d, want 1 0 0 0",
                     halted, imem_we, core_en, instr_cnt);
        end
        cycle(1'b1, C_LOAD, 4'd7, 8'h77, 1'b0);
        vectors++;
        if (imem_we !== 1'b0 || imem_waddr !== 4'd0 || imem_wdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_drops_load: got we=%b wa=%h wd=%h, want 0 0 00", imem_we, imem_waddr, imem_wdata);
        end
        idle_cycle();
    endtask

`ifdef CORE_EXEC_CTRL_BREAKPOINT_EN
    task automatic test_breakpoint();
        logic [7:0] seen;
        do_reset();
        bp_en = 1'b1;
        bp_addr = 4'd6;
        for (int i = 0; i < 8; i++) begin
            cycle(i == 0, C_RUN, '0, '0, 1'b1);
            seen[i] = obs_en;
        end
        vectors++;
        if (seen !== 8'b0111_1110 || bp_hit !== 1'b1 || halted !== 1'b1 || pc !== 4'd6) begin
            miscompares++;
            $display("FAIL bp_stop: got pattern=%b bp=%b halt=%b pc=%0d, want 01111110 1 1 6",
                     seen, bp_hit, halted, pc);
        end
        cycle(1'b1, C_RUN, '0, '0, 1'b1);
        vectors++;
        if (bp_hit !== 1'b0 || core_en !== 1'b1 || pc !== 4'd6) begin
            miscompares++;
            $display("FAIL bp_resume: got bp=%b en=%b pc=%0d, want 0 1 6", bp_hit, core_en, pc);
        end
        idle_cycle();
        vectors++;
        if (pc !== 4'd7 || core_en !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_continue: got pc=%0d en=%b, want 7 1", pc, core_en);
        end
        cycle(1'b1, C_HALT, '0, '0, 1'b1);
        bp_en = 1'b0;
        idle_cycle();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                bp_en   = 1'($urandom_range(0, 1));
                bp_addr = PC_W'($urandom);
            end
            cycle(($urandom % 10) < 6, 2'($urandom), PC_W'($urandom), INST_W'($urandom),
                  ($urandom % 100) != 0);
        end
        bp_en = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back_step();
        test_run_halt();
        test_saturate_and_reset();
`ifdef CORE_EXEC_CTRL_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
